// File: rtl/sigmoid_pkg.sv
// Shared types, breakpoint table and bf16 compare helpers for the piecewise sigmoid datapath.
package sigmoid_pkg;

    localparam int unsigned N_SEG = 16;
    localparam int unsigned IDX_W = $clog2(N_SEG);

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] fract;
    } bf16_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_DONE
    } state_e;

    localparam logic [15:0] BF16_QNAN = 16'h7FC0;

    // Entry 0 is never selected by the search; it stands in for -inf.
    localparam bf16_t SEG_BKPT [N_SEG] = '{
        bf16_t'(16'hFF80), bf16_t'(16'hC0E0), bf16_t'(16'hC0C0), bf16_t'(16'hC0A0),
        bf16_t'(16'hC080), bf16_t'(16'hC040), bf16_t'(16'hC000), bf16_t'(16'hBF80),
        bf16_t'(16'h0000), bf16_t'(16'h3F80), bf16_t'(16'h4000), bf16_t'(16'h4040),
        bf16_t'(16'h4080), bf16_t'(16'h40A0), bf16_t'(16'h40C0), bf16_t'(16'h40E0)
    };

    function automatic logic bf16_is_nan(bf16_t v);
        return (v.exp == 8'hFF) && (v.fract != 7'd0);
    endfunction

    // a < b with NaN never less and +0 equal to -0.
    function automatic logic bf16_lt(bf16_t a, bf16_t b);
        logic both_zero;
        both_zero = ({a.exp, a.fract} == 15'd0) && ({b.exp, b.fract} == 15'd0);
        if (bf16_is_nan(a) || bf16_is_nan(b)) begin
            return 1'b0;
        end
        if (a.sign != b.sign) begin
            return a.sign && !both_zero;
        end
        if (!a.sign) begin
            return {a.exp, a.fract} < {b.exp, b.fract};
        end
        return {a.exp, a.fract} > {b.exp, b.fract};
    endfunction

endpackage

// File: rtl/seg_bkpt_rom.sv
// Combinational breakpoint lookup: segment index -> bf16 breakpoint bits.
module seg_bkpt_rom
    import sigmoid_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    output logic [15:0]      bkpt_o
);

    assign bkpt_o = SEG_BKPT[idx_i];

endmodule

// File: rtl/bf16_seg_search.sv
// Binary search of a bf16 operand over the breakpoint table, one compare per cycle.
// Optional SEG_SAT_EN adds sat_o flagging the two outer (saturated) segments.
module bf16_seg_search
    import sigmoid_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [15:0]      x_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [IDX_W-1:0] seg_o,
    output logic [15:0]      x_o,
    output logic             nan_o
`ifdef SEG_SAT_EN
    ,
    output logic             sat_o
`endif
);

    state_e           state_q, state_d;
    bf16_t            x_q, x_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] bit_q, bit_d;
    logic [IDX_W-1:0] cand;
    logic             nan_q, nan_d;
    logic             valid_q, valid_d;
    logic [15:0]      bkpt;
    logic             accept;

    assign cand       = idx_q | (IDX_W'(1) << bit_q);
    assign in_ready_o = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    seg_bkpt_rom u_rom (
        .idx_i  (cand),
        .bkpt_o (bkpt)
    );

    // Next-state: search step, result hand-off, and operand capture (incl. back-to-back).
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        nan_d   = nan_q;
        case (state_q)
            S_SEARCH: begin
                if (!bf16_lt(x_q, bf16_t'(bkpt))) begin
                    idx_d = cand;
                end
                if (bit_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    bit_d = bit_q - IDX_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase
        if (accept) begin
            x_d     = bf16_t'(x_i);
            idx_d   = '0;
            bit_d   = IDX_W'(IDX_W - 1);
            nan_d   = bf16_is_nan(bf16_t'(x_i));
            state_d = nan_d ? S_DONE : S_SEARCH;
        end
        valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            idx_q   <= '0;
            bit_q   <= '0;
            nan_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            nan_q   <= nan_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid_o = valid_q;
    assign seg_o       = idx_q;
    assign x_o         = x_q;
    assign nan_o       = nan_q;

`ifdef SEG_SAT_EN
    logic sat_q, sat_d;

    assign sat_d = valid_d && !nan_d && ((idx_d == '0) || (idx_d == IDX_W'(N_SEG - 1)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_o = sat_q;
`endif

endmodule

// File: tb/tb_bf16_seg_search.sv
// Self-checking bench for bf16_seg_search against a real-valued reference model.
`timescale 1ns/1ps
module tb_bf16_seg_search;

    localparam int unsigned IDX_W = 4;
    localparam int unsigned NSEG  = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x_in;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  seg_out;
    logic [15:0] x_out;
    logic        nan_out;
`ifdef SEG_SAT_EN
    logic        sat_out;
`endif

    int total = 0;
    int bad   = 0;

    logic [15:0] tb_bkpt [16] = '{
        16'hFF80, 16'hC0E0, 16'hC0C0, 16'hC0A0, 16'hC080, 16'hC040, 16'hC000, 16'hBF80,
        16'h0000, 16'h3F80, 16'h4000, 16'h4040, 16'h4080, 16'h40A0, 16'h40C0, 16'h40E0
    };

    bf16_seg_search dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .x_i         (x_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .seg_o       (seg_out),
        .x_o         (x_out),
        .nan_o       (nan_out)
`ifdef SEG_SAT_EN
        ,
        .sat_o       (sat_out)
`endif
    );

    always #5 clk = ~clk;

    function automatic bit is_nan(logic [15:0] v);
        return (v[14:7] == 8'hFF) && (v[6:0] != 7'd0);
    endfunction

    function automatic real bf2r(logic [15:0] v);
        real m;
        int  e;
        if (v[14:7] == 8'hFF) begin
            m = 1.0e300;
        end else begin
            e = int'(v[14:7]);
            if (e == 0) begin
                m = real'(v[6:0]) / 128.0;
                e = 1;
            end else begin
                m = 1.0 + real'(v[6:0]) / 128.0;
            end
            for (int i = e; i < 127; i++) m = m / 2.0;
            for (int i = 127; i < e; i++) m = m * 2.0;
        end
        return v[15] ? -m : m;
    endfunction

    function automatic int ref_seg(logic [15:0] v);
        int  cnt;
        real xr;
        cnt = 0;
        if (is_nan(v)) return 0;
        xr = bf2r(v);
        for (int k = 1; k < 16; k++) begin
            if (bf2r(tb_bkpt[k]) <= xr) cnt++;
        end
        return cnt;
    endfunction

    // One isolated transaction from IDLE; lat = edges after the accept edge until out_valid.
    task automatic run_one(input logic [15:0] x, output logic [3:0] seg, output logic [15:0] xo,
                           output logic nan, output logic sat, output int lat);
        @(negedge clk);
        in_valid  = 1'b1;
        x_in      = x;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        seg = seg_out;
        xo  = x_out;
        nan = nan_out;
`ifdef SEG_SAT_EN
        sat = sat_out;
`else
        sat = 1'b0;
`endif
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x_in = 16'h1234;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({out_valid, seg_out, x_out, nan_out} !== 22'd0) begin
            bad++;
            $display("FAIL reset_outputs: valid=%0b seg=%0d x=%h nan=%0b want all zero",
                     out_valid, seg_out, x_out, nan_out);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: in_ready=%0b want 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_boundary();
        logic [15:0] xs [12] = '{16'hC040, 16'hC041, 16'h4080, 16'h407F, 16'hFF80, 16'h7F80,
                                 16'h8000, 16'h0000, 16'h0001, 16'h8001, 16'hC100, 16'h40E0};
        int          es [12] = '{5, 4, 12, 11, 0, 15, 8, 8, 8, 7, 0, 15};
        logic [3:0]  seg;
        logic [15:0] xo;
        logic        nan, sat;
        int          lat;
        for (int i = 0; i < 12; i++) begin
            run_one(xs[i], seg, xo, nan, sat, lat);
            total++;
            if (seg !== 4'(es[i]) || nan !== 1'b0 || xo !== xs[i] || lat != IDX_W) begin
                bad++;
                $display("FAIL boundary x=%h: seg=%0d nan=%0b xo=%h lat=%0d want seg=%0d nan=0 xo=%h lat=%0d",
                         xs[i], seg, nan, xo, lat, es[i], xs[i], IDX_W);
            end
        end
    endtask

    task automatic test_nan();
        logic [15:0] xs [3] = '{16'h7FC0, 16'hFFFF, 16'h7F81};
        logic [3:0]  seg;
        logic [15:0] xo;
        logic        nan, sat;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            run_one(xs[i], seg, xo, nan, sat, lat);
            total++;
            if (seg !== 4'd0 || nan !== 1'b1 || xo !== xs[i] || lat != 0) begin
                bad++;
                $display("FAIL nan x=%h: seg=%0d nan=%0b xo=%h lat=%0d want seg=0 nan=1 xo=%h lat=0",
                         xs[i], seg, nan, xo, lat, xs[i]);
            end
        end
    endtask

    task automatic test_stall();
        int lat;
        bit unstable;
        @(negedge clk);
        in_valid = 1'b1; x_in = 16'h4000; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        unstable = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (!out_valid || in_ready || seg_out !== 4'd10 || x_out !== 16'h4000) unstable = 1'b1;
        end
        total++;
        if (unstable) begin
            bad++;
            $display("FAIL stall_hold: valid=%0b ready=%0b seg=%0d xo=%h want 1 0 10 4000",
                     out_valid, in_ready, seg_out, x_out);
        end
        @(negedge clk);
        in_valid = 1'b1; x_in = 16'hC0A0; out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_release_ready: in_ready=%0b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        total++;
        if (lat != IDX_W || seg_out !== 4'd3 || x_out !== 16'hC0A0) begin
            bad++;
            $display("FAIL stall_next: lat=%0d seg=%0d xo=%h want lat=%0d seg=3 xo=c0a0",
                     lat, seg_out, x_out, IDX_W);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit          seen;
        logic [3:0]  seg;
        logic [15:0] xo;
        logic        nan, sat;
        int          lat;
        @(negedge clk);
        in_valid = 1'b1; x_in = 16'h40C0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || seg_out !== 4'd0 || x_out !== 16'd0) begin
            bad++;
            $display("FAIL reset_mid_clear: valid=%0b seg=%0d xo=%h want 0 0 0000", out_valid, seg_out, x_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        total++;
        if (seen || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_ghost: result_seen=%0b ready=%0b want 0 1", seen, in_ready);
        end
        run_one(16'h3F80, seg, xo, nan, sat, lat);
        total++;
        if (seg !== 4'd9 || xo !== 16'h3F80 || lat != IDX_W) begin
            bad++;
            $display("FAIL reset_mid_next: seg=%0d xo=%h lat=%0d want 9 3f80 %0d", seg, xo, lat, IDX_W);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] arr [12];
        int          exp_q [$];
        int          sent, rcv, first_acc, last_acc, e;
        for (int i = 0; i < 12; i++) begin
            arr[i] = 16'($urandom);
            if (arr[i][14:7] == 8'hFF) arr[i][14] = 1'b0;
        end
        sent = 0; rcv = 0; first_acc = -1; last_acc = -1;
        for (int cyc = 0; cyc < 300 && rcv < 12; cyc++) begin
            @(negedge clk);
            in_valid  = (sent < 12);
            x_in      = (sent < 12) ? arr[sent] : 16'h0;
            out_ready = 1'b1;
            #1;
            if (out_valid && out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                rcv++;
                total++;
                if (seg_out !== 4'(e) || e < 0) begin
                    bad++;
                    $display("FAIL b2b_result #%0d: seg=%0d want %0d", rcv, seg_out, e);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_seg(x_in));
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                sent++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        total++;
        if (rcv != 12 || (last_acc - first_acc) != 11 * (IDX_W + 1)) begin
            bad++;
            $display("FAIL b2b_throughput: received=%0d span=%0d want 12 %0d",
                     rcv, last_acc - first_acc, 11 * (IDX_W + 1));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random(input int n);
        logic [15:0] x, xo;
        logic [3:0]  seg;
        logic        nan, sat;
        int          lat, es, elat;
        bit          en;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                x = tb_bkpt[$urandom_range(1, 15)] + 16'($urandom_range(0, 4)) - 16'd2;
            end else begin
                x = 16'($urandom);
            end
            run_one(x, seg, xo, nan, sat, lat);
            es   = ref_seg(x);
            en   = is_nan(x);
            elat = en ? 0 : IDX_W;
            total++;
            if (seg !== 4'(es) || nan !== en || xo !== x || lat != elat
`ifdef SEG_SAT_EN
                || sat !== (((es == 0) || (es == NSEG - 1)) && !en)
`endif
               ) begin
                bad++;
                $display("FAIL random x=%h: seg=%0d nan=%0b xo=%h lat=%0d sat=%0b want seg=%0d nan=%0b lat=%0d",
                         x, seg, nan, xo, lat, sat, es, en, elat);
            end
        end
    endtask

`ifdef SEG_SAT_EN
    task automatic test_sat();
        logic [15:0] xs [4] = '{16'hC100, 16'hBF80, 16'h7F80, 16'h7FC0};
        logic        es [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0]  seg;
        logic [15:0] xo;
        logic        nan, sat;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            run_one(xs[i], seg, xo, nan, sat, lat);
            total++;
            if (sat !== es[i]) begin
                bad++;
                $display("FAIL sat x=%h: sat=%0b want %0b (seg=%0d)", xs[i], sat, es[i], seg);
            end
        end
    endtask
`endif

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_boundary();
        test_nan();
        test_stall();
        test_reset_mid();
        test_back_to_back();
`ifdef SEG_SAT_EN
        test_sat();
`endif
        test_random(3000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
